// File: rtl/stage2_if.sv
// stage2_if: decode-to-execute operands plus the registered execute results and stall.
interface stage2_if;
  logic        in_valid;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [4:0]  wtsel;
  logic [15:0] imm;
  logic        datasrc;
  logic [2:0]  aop;
  logic [31:0] result;
  logic        zero;
  logic [4:0]  ws_out;
  logic        wen_out;
  logic        stall;
  modport master (
    output in_valid, rdata1, rdata2, wtsel, imm, datasrc, aop,
    input  result, zero, ws_out, wen_out, stall
  );
  modport slave (
    input  in_valid, rdata1, rdata2, wtsel, imm, datasrc, aop,
    output result, zero, ws_out, wen_out, stall
  );
endinterface

// File: rtl/stage2.sv
// stage2: execute stage; single-cycle ALU ops, iterative shift-add multiply that stalls upstream.
module stage2 #(
  parameter int MUL_CYCLES = 32
) (
  input logic     clk,
  input logic     rst,
  stage2_if.slave bus
);
  localparam int CW = $clog2(MUL_CYCLES);
  typedef enum logic {IDLE, MUL} state_t;
  state_t        state;
  logic [31:0]   a, b, alu, mcand, mplier, acc, acc_nxt;
  logic [CW-1:0] cnt;
  always_comb begin
    a = bus.rdata1;
    b = bus.datasrc ? {{16{bus.imm[15]}}, bus.imm} : bus.rdata2;
    alu = bus.aop == 3'd0 ? a + b :
          bus.aop == 3'd1 ? a - b :
          bus.aop == 3'd2 ? a & b :
          bus.aop == 3'd3 ? a | b :
          bus.aop == 3'd4 ? a ^ b :
          bus.aop == 3'd5 ? a << b[4:0] :
          bus.aop == 3'd6 ? {31'd0, $signed(a) < $signed(b)} : 32'd0;
    acc_nxt = mplier[0] ? acc + mcand : acc;
  end
  assign bus.stall = state == MUL;
  // The last iteration's partial product is folded in directly so the result lands on the exit edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      bus.result  <= '0;
      bus.zero    <= 1'b0;
      bus.ws_out  <= '0;
      bus.wen_out <= 1'b0;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      cnt         <= '0;
    end else begin
      bus.wen_out <= 1'b0;
      if (state == IDLE) begin
        if (bus.in_valid && bus.aop == 3'd7) begin
          mcand      <= a;
          mplier     <= b;
          bus.ws_out <= bus.wtsel;
          acc        <= '0;
          cnt        <= '0;
          state      <= MUL;
        end else if (bus.in_valid) begin
          bus.result  <= alu;
          bus.zero    <= alu == 32'd0;
          bus.ws_out  <= bus.wtsel;
          bus.wen_out <= 1'b1;
        end
      end else begin
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        if (cnt == CW'(MUL_CYCLES - 1)) begin
          bus.result  <= acc_nxt;
          bus.zero    <= acc_nxt == 32'd0;
          bus.wen_out <= 1'b1;
          state       <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_stage2.sv
// tb_stage2: directed and random checks of stage2 against an arithmetic reference model.
module tb_stage2;
  localparam int MC = 32;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  stage2_if bus();
  stage2 #(.MUL_CYCLES(MC)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] r2,
                                        input logic [15:0] imm, input logic ds, input logic [2:0] aop);
    logic [31:0] b;
    logic [63:0] p;
    b = ds ? {{16{imm[15]}}, imm} : r2;
    p = 64'(a) * 64'(b);
    case (aop)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << (b % 32);
      3'd6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return p[31:0];
    endcase
  endfunction
  task automatic check_zero_outs(input string tag);
    chk({tag, " result"}, bus.result, 32'd0);
    chk({tag, " zero"}, 32'(bus.zero), 32'd0);
    chk({tag, " ws_out"}, 32'(bus.ws_out), 32'd0);
    chk({tag, " wen_out"}, 32'(bus.wen_out), 32'd0);
    chk({tag, " stall"}, 32'(bus.stall), 32'd0);
  endtask
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] r2, input logic [15:0] imm,
                       input logic ds, input logic [2:0] aop, input logic [4:0] ws);
    bus.in_valid = v;
    bus.rdata1   = a;
    bus.rdata2   = r2;
    bus.imm      = imm;
    bus.datasrc  = ds;
    bus.aop      = aop;
    bus.wtsel    = ws;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("idle wen_out", 32'(bus.wen_out), 32'd0);
      chk("idle stall", 32'(bus.stall), 32'd0);
    end
  endtask
  task automatic exec(input string tag, input logic [31:0] a, input logic [31:0] r2, input logic [15:0] imm,
                      input logic ds, input logic [2:0] aop, input logic [4:0] ws);
    logic [31:0] exp;
    int n;
    exp = model(a, r2, imm, ds, aop);
    @(negedge clk);
    drive(1'b1, a, r2, imm, ds, aop, ws);
    @(posedge clk);
    #1;
    if (aop == 3'd7) begin
      n = 0;
      while (bus.stall && n <= MC + 4) begin
        n++;
        chk({tag, " wen during stall"}, 32'(bus.wen_out), 32'd0);
        @(negedge clk);
        drive(n[0], $urandom, $urandom, 16'($urandom), 1'($urandom), (n % 3 == 0) ? 3'd7 : 3'($urandom), 5'($urandom));
        @(posedge clk);
        #1;
      end
      chk({tag, " stall cycles"}, 32'(n), 32'(MC));
    end
    chk({tag, " result"}, bus.result, exp);
    chk({tag, " zero"}, 32'(bus.zero), 32'(exp == 32'd0));
    chk({tag, " ws_out"}, 32'(bus.ws_out), 32'(ws));
    chk({tag, " wen_out"}, 32'(bus.wen_out), 32'd1);
    chk({tag, " stall after"}, 32'(bus.stall), 32'd0);
  endtask
  initial begin
    drive(1'b0, 0, 0, 0, 1'b0, 3'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    check_zero_outs("reset");
    @(negedge clk);
    rst = 1'b1;
    idle(3);
    exec("add imm", 32'd5, 32'd0, 16'hFFFD, 1'b1, 3'd0, 5'd7);
    idle(1);
    exec("sub", 32'd5, 32'd5, 16'd0, 1'b0, 3'd1, 5'd2);
    exec("slt", 32'hFFFFFFFF, 32'd1, 16'd0, 1'b0, 3'd6, 5'd4);
    exec("sll", 32'd1, 32'd35, 16'd0, 1'b0, 3'd5, 5'd5);
    idle(1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_zero_outs("async reset");
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    exec("mul", 32'h00010001, 32'h00010001, 16'd0, 1'b0, 3'd7, 5'd3);
    idle(1);
    exec("mul neg", 32'hFFFFFFFF, 32'd3, 16'd0, 1'b0, 3'd7, 5'd9);
    exec("b2b add", 32'd100, 32'd23, 16'd0, 1'b0, 3'd0, 5'd11);
    idle(1);
    @(negedge clk);
    drive(1'b1, 32'd7, 32'd9, 16'd0, 1'b0, 3'd7, 5'd6);
    @(posedge clk);
    #1;
    chk("midmul stall", 32'(bus.stall), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_zero_outs("midmul reset");
    @(negedge clk);
    rst = 1'b1;
    idle(MC + 2);
    exec("post reset add", 32'd40, 32'd2, 16'd0, 1'b0, 3'd0, 5'd8);
    for (int i = 0; i < 30; i++) begin
      exec("random", $urandom, $urandom, 16'($urandom), 1'($urandom), 3'($urandom), 5'($urandom));
      if ($urandom_range(0, 2) == 0) idle(1);
    end
    idle(1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/stage2.md
# stage2

Execute stage of the pipelined datapath, sitting directly downstream of the decode/register-read stage (`stage1`). It is driven by:

- the decode stage's registered fields: write select, 16-bit immediate, data-source bit and 3-bit ALU op;
- the register file's two read-data buses.

It computes the ALU result and registers it together with the destination register index and a write-enable pulse. Those outputs feed write-back, which returns them as write data and previous write select. Multiply is iterative and stalls upstream; every other op completes in one cycle.

## Interface

Parameters:
- `MUL_CYCLES`, default 32: shift-add iterations per multiply. Must equal the data width.

Ports:
- `clk`  in  1  clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  the decode outputs hold a valid instruction this cycle.
- `rdata1`  in  32  operand A, from register-file read port 1.
- `rdata2`  in  32  operand B candidate, from register-file read port 2.
- `wtsel`  in  5  destination register index.
- `imm`  in  16  immediate field.
- `datasrc`  in  1  selects operand B: 1 = sign-extended `imm`, 0 = `rdata2`.
- `aop`  in  3  ALU operation code.
- `result`  out  32  registered ALU result.
- `zero`  out  1  registered flag: `result == 0`.
- `ws_out`  out  5  registered destination index; goes to write-back as write select.
- `wen_out`  out  1  one-cycle pulse: `result`/`ws_out` are valid for write-back.
- `stall`  out  1  stage busy with a multiply; upstream must hold its outputs.

## Operation

- Operand B is `datasrc ? {{16{imm[15]}}, imm} : rdata2`.
- aop codes:
  - 000 ADD: A+B, mod 2^32.
  - 001 SUB: A−B, mod 2^32.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SLL: A << B[4:0].
  - 110 SLT: signed compare; result is 1 if A<B, else 0.
  - 111 MUL: low 32 bits of A×B. Unsigned and signed give identical low bits.
- Register index 0 gets no special treatment here; write-back handles it.
- State machine:
  - IDLE: an instruction is accepted when `in_valid`=1.
    - For a non-MUL op, compute combinationally and register `result`, `zero`, `ws_out` and `wen_out`=1 at the next edge; stay in IDLE.
    - For MUL, capture A into a multiplicand register, B into a multiplier register and `wtsel` into `ws_out`. Clear the accumulator, set counter = 0 and go to MUL.
  - IDLE with `in_valid`=0: `wen_out` is 0; `result`, `zero` and `ws_out` hold.
  - MUL: each cycle, if multiplier[0] is set, the accumulator adds the multiplicand. Then the multiplicand shifts left by 1, the multiplier shifts right by 1, and the counter increments.
  - MUL exit: at the edge where the counter equals `MUL_CYCLES`−1, load `result` = final accumulator and `zero` accordingly, pulse `wen_out`=1 and return to IDLE.
- `stall` = (state == MUL), decoded combinationally from the state register.
- `in_valid` and all data inputs are ignored while in MUL.

## Timing

- Reset values (async, on `rst`=0): `result`=0, `zero`=0, `ws_out`=0, `wen_out`=0, `stall`=0, state=IDLE. The accumulator, operand registers and counter are also cleared.
- Reset asserted mid-multiply aborts it: no `wen_out` pulse, and the stage returns to IDLE.
- Non-MUL latency: 1 cycle. Inputs sampled at edge N produce `result` and `wen_out`=1 visible after edge N.
- MUL latency:
  - accepted at edge N;
  - `stall`=1 from after edge N through edge N+32;
  - `result` and `wen_out`=1 are visible after edge N+32, when `stall` also falls.
- An instruction presented in the cycle after MUL completes is accepted normally; there are no bubbles between back-to-back instructions.
- `wen_out` is never high for two cycles from one instruction.
- `in_valid` with MUL presented while `stall`=1 must not restart the multiply.

## Test plan

- Reset then idle: assert `rst`=0 mid-run. All outputs are 0 immediately and asynchronously; after release with `in_valid`=0, `wen_out` stays 0.
- ADD with immediate: A=5, `imm`=16'hFFFD, `datasrc`=1, `aop`=000, `wtsel`=7. One cycle later: `result`=2, `ws_out`=7, `wen_out`=1 for 1 cycle, `zero`=0.
- SUB/SLT/SLL: 5−5 gives `result`=0 and `zero`=1. SLT with A=32'hFFFFFFFF, B=1 gives 1. SLL with A=1, B=35 gives 8 (shift amount wraps to 3).
- MUL: A=32'h00010001, B=32'h00010001, `wtsel`=3.
  - `stall`=1 for exactly 32 cycles, with `in_valid` toggling and the inputs changed during the stall.
  - Then `result`=32'h00020001, `ws_out`=3, and `wen_out` pulses once.
- MUL overflow/sign: A=32'hFFFFFFFF (−1), B=3 gives 32'hFFFFFFFD. A back-to-back ADD issued in the cycle after `stall` falls completes 1 cycle later.
- Reset mid-MUL: drop `rst` at iteration 10. The stage goes to IDLE with `stall`=0, no `wen_out` pulse and `result`=0; a following ADD operates normally.
